// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit producing HI/LO for MULT,
// MULTU, DIV, DIVU, MTHI and MTLO.
//
// The multiplier is shift-add and the divider is restoring. Both work on
// operand magnitudes and share one 2*Data_Size accumulator. The sign fix-up
// is applied when HI/LO are written.
//
// Optional build macro MDU_DIV_ZERO_FLAG_EN adds the DIV_ZERO status output.
//
// state  | meaning
// IDLE   | waiting; START latches operands, MTHI/MTLO write HI/LO
// CALC   | one shift/add or shift/subtract step per clock, Data_Size steps
// FINISH | sign correction; HI/LO and DONE are registered on exit
module mult_div_unit #(
    parameter int Data_Size = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [1:0]           OP,
    input  logic [Data_Size-1:0] SRC_A,
    input  logic [Data_Size-1:0] SRC_B,
    input  logic                 MTHI,
    input  logic                 MTLO,
    input  logic [Data_Size-1:0] WR_DATA,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [Data_Size-1:0] HI,
    output logic [Data_Size-1:0] LO
`ifdef MDU_DIV_ZERO_FLAG_EN
    ,
    output logic                 DIV_ZERO
`endif
);

    localparam int N  = Data_Size;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            is_div, sign_a, sign_b, b_zero;
    logic [N-1:0]    a_mag, b_mag, a_raw;
    logic [2*N-1:0]  acc, acc_nxt;
    logic [N-1:0]    a_mag_in, b_mag_in;
    logic [N:0]      mul_sum, div_shift, div_diff;
    logic            div_ge;
    logic [2*N-1:0]  prod_s;
    logic [N-1:0]    quo_s, rem_s, res_hi, res_lo;
    logic            done_q;

    // Signed ops work on the two's-complement magnitude. The most-negative
    // value maps onto itself, which is still the correct unsigned magnitude.
    assign a_mag_in = (OP[0] && SRC_A[N-1]) ? -SRC_A : SRC_A;
    assign b_mag_in = (OP[0] && SRC_B[N-1]) ? -SRC_B : SRC_B;

    assign BUSY = (state != S_IDLE);
    assign DONE = done_q;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (START) state_nxt = S_CALC;
            S_CALC:   if (cnt == CNT_LAST) state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Iteration counter, 0..Data_Size-1 while in CALC
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                cnt <= '0;
        else if (state == S_CALC) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        else                     cnt <= '0;
    end

    // One datapath step. Multiply keeps {partial, multiplier} and shifts right.
    // Divide keeps {remainder, quotient} and shifts left.
    always_comb begin
        mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, a_mag} : '0);
        div_shift = acc[2*N-1:N-1];
        div_diff  = div_shift - {1'b0, b_mag};
        div_ge    = ~div_diff[N];
        if (is_div)
            acc_nxt = {(div_ge ? div_diff[N-1:0] : div_shift[N-1:0]), acc[N-2:0], div_ge};
        else
            acc_nxt = {mul_sum, acc[N-1:1]};
    end

    // Operand capture at START, then accumulator stepping during CALC
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            a_mag  <= '0;
            b_mag  <= '0;
            a_raw  <= '0;
            acc    <= '0;
        end else if (state == S_IDLE && START) begin
            is_div <= OP[1];
            sign_a <= OP[0] & SRC_A[N-1];
            sign_b <= OP[0] & SRC_B[N-1];
            b_zero <= (SRC_B == '0);
            a_mag  <= a_mag_in;
            b_mag  <= b_mag_in;
            a_raw  <= SRC_A;
            acc    <= {{N{1'b0}}, (OP[1] ? a_mag_in : b_mag_in)};
        end else if (state == S_CALC) begin
            acc    <= acc_nxt;
        end
    end

    // Sign correction and result selection
    always_comb begin
        prod_s = (sign_a ^ sign_b) ? -acc : acc;
        quo_s  = (sign_a ^ sign_b) ? -acc[N-1:0] : acc[N-1:0];
        rem_s  = sign_a ? -acc[2*N-1:N] : acc[2*N-1:N];
        if (!is_div) begin
            res_hi = prod_s[2*N-1:N];
            res_lo = prod_s[N-1:0];
        end else if (b_zero) begin
            res_hi = a_raw;
            res_lo = '1;
        end else begin
            res_hi = rem_s;
            res_lo = quo_s;
        end
    end

    // HI/LO: the result is written on leaving FINISH, and moves are taken only in IDLE
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            HI <= '0;
            LO <= '0;
        end else if (state == S_FINISH) begin
            HI <= res_hi;
            LO <= res_lo;
        end else if (state == S_IDLE) begin
            if (MTHI) HI <= WR_DATA;
            if (MTLO) LO <= WR_DATA;
        end
    end

    // DONE pulses for the single cycle after FINISH
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) done_q <= 1'b0;
        else      done_q <= (state == S_FINISH);
    end

`ifdef MDU_DIV_ZERO_FLAG_EN
    // Divide-by-zero flag, refreshed by every completed operation
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                   DIV_ZERO <= 1'b0;
        else if (state == S_FINISH) DIV_ZERO <= is_div & b_zero;
    end
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: table of operations, then handshake,
// mid-operation interference and reset-abort sequences.
module tb_mult_div_unit;

    logic        CLK, RST, START, MTHI, MTLO;
    logic [1:0]  OP;
    logic [31:0] SRC_A, SRC_B, WR_DATA;
    logic        BUSY, DONE;
    logic [31:0] HI, LO;
`ifdef MDU_DIV_ZERO_FLAG_EN
    logic        DIV_ZERO;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit #(.Data_Size(32)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP),
        .SRC_A(SRC_A), .SRC_B(SRC_B), .MTHI(MTHI), .MTLO(MTLO),
        .WR_DATA(WR_DATA), .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO)
`ifdef MDU_DIV_ZERO_FLAG_EN
        , .DIV_ZERO(DIV_ZERO)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for DONE. Returns the number of
    // edges from the START edge to DONE and how many of those samples had BUSY high.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt);
        @(posedge CLK); #1;
        START = 1'b1; OP = op; SRC_A = a; SRC_B = b;
        @(posedge CLK); #1;
        START = 1'b0; SRC_A = $urandom; SRC_B = $urandom; OP = 2'($urandom_range(0, 3));
        bcnt = BUSY ? 1 : 0;
        lat  = 0;
        while (lat < 100) begin
            @(posedge CLK); #1;
            lat++;
            if (DONE) break;
            if (BUSY) bcnt++;
        end
    endtask

    initial begin
        int lat, bcnt, done_cnt, done_at;

        vecs[0]  = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[3]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5]  = '{2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{2'b00, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0};
        vecs[7]  = '{2'b11, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1};
        vecs[8]  = '{2'b01, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
        vecs[9]  = '{2'b11, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0};
        vecs[10] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[11] = '{2'b11, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
        vecs[12] = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};

        RST = 1'b0; START = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
        OP = 2'b00; SRC_A = '0; SRC_B = '0; WR_DATA = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_busy", {31'b0, BUSY}, 32'd0);
        check("reset_done", {31'b0, DONE}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
`ifdef MDU_DIV_ZERO_FLAG_EN
        check("reset_divzero", {31'b0, DIV_ZERO}, 32'd0);
`endif
        RST = 1'b1;

        // Table of operations
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            check($sformatf("v%0d_latency", i), lat, 32'd33);
            check($sformatf("v%0d_busy_cycles", i), bcnt, 32'd33);
            check($sformatf("v%0d_busy_at_done", i), {31'b0, BUSY}, 32'd0);
            check($sformatf("v%0d_hi", i), HI, vecs[i].hi);
            check($sformatf("v%0d_lo", i), LO, vecs[i].lo);
`ifdef MDU_DIV_ZERO_FLAG_EN
            check($sformatf("v%0d_divzero", i), {31'b0, DIV_ZERO}, {31'b0, vecs[i].dz});
`endif
            @(posedge CLK); #1;
            check($sformatf("v%0d_done_pulse", i), {31'b0, DONE}, 32'd0);
        end

        // Moves in IDLE
        MTHI = 1'b1; WR_DATA = 32'hAAAA0000;
        @(posedge CLK); #1;
        MTHI = 1'b0;
        check("mthi_hi", HI, 32'hAAAA0000);
        MTLO = 1'b1; WR_DATA = 32'h0000CAFE;
        @(posedge CLK); #1;
        MTLO = 1'b0;
        check("mtlo_lo", LO, 32'h0000CAFE);
        check("mtlo_hi_kept", HI, 32'hAAAA0000);

        // Second START and MTLO in the middle of CALC must be ignored
        START = 1'b1; OP = 2'b00; SRC_A = 32'd2; SRC_B = 32'd3;
        @(posedge CLK); #1;
        START = 1'b0;
        done_cnt = 0; done_at = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 5) begin
                START = 1'b1; OP = 2'b11; SRC_A = 32'd99; SRC_B = 32'd9;
                MTLO = 1'b1; MTHI = 1'b1; WR_DATA = 32'hDEADBEEF;
            end
            @(posedge CLK); #1;
            if (k == 5) begin
                START = 1'b0; MTLO = 1'b0; MTHI = 1'b0;
                check("midcalc_lo_kept", LO, 32'h0000CAFE);
                check("midcalc_hi_kept", HI, 32'hAAAA0000);
            end
            if (DONE) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
        end
        check("midcalc_done_count", done_cnt, 32'd1);
        check("midcalc_done_at", done_at, 32'd33);
        check("midcalc_hi", HI, 32'd0);
        check("midcalc_lo", LO, 32'd6);

        // Reset abort mid-operation
        START = 1'b1; OP = 2'b01; SRC_A = 32'hFFFFFFFD; SRC_B = 32'd5;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        check("abort_busy_before", {31'b0, BUSY}, 32'd1);
        RST = 1'b0;
        #1;
        check("abort_busy", {31'b0, BUSY}, 32'd0);
        check("abort_done", {31'b0, DONE}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        run_op(2'b00, 32'd4, 32'd4, lat, bcnt);
        check("post_reset_latency", lat, 32'd33);
        check("post_reset_hi", HI, 32'd0);
        check("post_reset_lo", LO, 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
